// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant lasts for a burst of up to MAX_BURST accepted beats. Every burst is
// followed by at least one IDLE cycle. Outputs are decoded combinationally
// from the registered grant, so an asynchronous reset drops fifo_wr_en at once.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic [ID_W-1:0]           owner_id,
  output logic                      busy,
  output logic [15:0]               burst_cnt
);

  localparam logic [0:0]      ST_IDLE   = 1'b0;
  localparam logic [0:0]      ST_BURST  = 1'b1;
  localparam logic [3:0]      BURST_MAX = 4'(MAX_BURST);
  localparam logic [ID_W-1:0] LAST_RST  = ID_W'(NUM_REQ - 1);

  logic [0:0]      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] last_owner_q, last_owner_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;
  logic [15:0]     burst_cnt_q, burst_cnt_d;

  logic [DATA_W-1:0] slice_w [NUM_REQ];
  logic              own_req, own_last;
  logic [DATA_W-1:0] own_data;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;

  // Split the flat data bus into one word per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign slice_w[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Select the current owner's request, last flag and data word.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_W'(i)) begin
        own_req  = req[i];
        own_last = req_last[i];
        own_data = slice_w[i];
      end
    end
  end

  // Round-robin search upward from last_owner+1 with wrap: candidates above
  // last_owner win over wrapped ones, and the lowest index wins within a group.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (ID_W'(j) <= last_owner_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (ID_W'(j) > last_owner_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
  end

  assign busy         = (state_q == ST_BURST);
  assign fifo_wr_en   = busy & own_req & ~fifo_full;
  assign fifo_wr_data = busy ? own_data : '0;
  assign owner_id     = owner_q;
  assign burst_cnt    = burst_cnt_q;

  // One-hot acknowledge to the owner on every accepted beat.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign ack[gi] = fifo_wr_en & (owner_q == ID_W'(gi));
    end
  endgenerate

  // Grant in IDLE; count beats in BURST and leave on last, max count or drop.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          owner_d      = grant_idx;
          last_owner_d = grant_idx;
          beat_cnt_d   = '0;
          state_d      = ST_BURST;
        end
      end
      default: begin
        if (!own_req) begin
          // Requester dropped out: release the grant without counting a burst.
          state_d = ST_IDLE;
        end else if (fifo_wr_en) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          // Last beat and max count on the same beat is still one burst.
          if (own_last || (beat_cnt_d == BURST_MAX)) begin
            state_d     = ST_IDLE;
            burst_cnt_d = burst_cnt_q + 16'd1;
          end
        end
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_RST;
      beat_cnt_q   <= '0;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a cycle table for the first packet,
// then a requester model feeding a write scoreboard for the multi-cycle cases.
module tb_fifo_wr_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req, req_last, ack, ack1;
  logic [NR*DW-1:0]  req_data;
  logic              fifo_full, wr_en, wr_en1, busy, busy1;
  logic [DW-1:0]     wr_data, wr_data1;
  logic [IDW-1:0]    owner_id, owner_id1;
  logic [15:0]       burst_cnt, burst_cnt1;

  // Requester inputs come either from the manual table drive or the model.
  logic              auto_en;
  logic [NR-1:0]     a_req, a_last, m_req, m_last;
  logic [NR*DW-1:0]  a_data, m_data;

  assign req      = auto_en ? a_req  : m_req;
  assign req_last = auto_en ? a_last : m_last;
  assign req_data = auto_en ? a_data : m_data;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .fifo_full(fifo_full), .fifo_wr_en(wr_en), .fifo_wr_data(wr_data),
    .owner_id(owner_id), .busy(busy), .burst_cnt(burst_cnt)
  );

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack1), .fifo_full(fifo_full), .fifo_wr_en(wr_en1), .fifo_wr_data(wr_data1),
    .owner_id(owner_id1), .busy(busy1), .burst_cnt(burst_cnt1)
  );

  typedef struct {
    logic       req0;
    logic       last0;
    logic [7:0] data0;
    logic       full;
    logic       exp_wr;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  typedef struct {
    int         owner;
    logic [7:0] data;
  } exp_t;

  vec_t       tbl [5];
  exp_t       exp_q [$];
  exp_t       e_mon;
  logic [7:0] src_data [NR][64];
  logic       src_last [NR][64];
  int         src_len [NR];
  int         src_ptr [NR];
  logic [NR-1:0] ack_s;
  int         n_chk, n_fail, wr_count, wr_count1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic refresh_auto();
    for (int i = 0; i < NR; i++) begin
      a_req[i]         = (src_ptr[i] < src_len[i]);
      a_data[i*DW +: DW] = a_req[i] ? src_data[i][src_ptr[i]] : 8'h00;
      a_last[i]        = a_req[i] && src_last[i][src_ptr[i]];
    end
  endtask

  // Queue a packet of n beats on requester i; optionally expect it in order.
  task automatic add_pkt(input int i, input int n, input logic [7:0] base,
                         input logic end_last, input logic push_exp);
    for (int k = 0; k < n; k++) begin
      src_data[i][src_len[i]] = base + 8'(k);
      src_last[i][src_len[i]] = end_last && (k == n - 1);
      src_len[i]++;
      if (push_exp) exp_q.push_back('{owner: i, data: base + 8'(k)});
    end
    refresh_auto();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    auto_en   = 1'b1;
    fifo_full = 1'b0;
    m_req = '0; m_last = '0; m_data = '0;
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
    end
    exp_q.delete();
    refresh_auto();
    wr_count  = 0;
    wr_count1 = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_burst_cnt(input int target, input string name);
    int n = 0;
    while (burst_cnt != 16'(target) && n < 300) begin
      tick();
      n++;
    end
    chk(name, 32'(burst_cnt), 32'(target));
  endtask

  task automatic wait_owner(input int o, input string name);
    int n = 0;
    while (!(busy && owner_id == IDW'(o)) && n < 100) begin
      tick();
      n++;
    end
    chk(name, {29'b0, busy, owner_id}, {29'b0, 1'b1, IDW'(o)});
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Compare every observed write against the scoreboard head.
  task automatic monitor_step();
    ack_s = ack;
    if (!rst) begin
      chk("no_write_while_full", 32'(wr_en & fifo_full), 32'd0);
      if (wr_en) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: actual data=0x%0h owner=%0d, required no write",
                   wr_data, owner_id);
        end else begin
          e_mon = exp_q.pop_front();
          chk("wr_owner", 32'(owner_id), 32'(e_mon.owner));
          chk("wr_data", 32'(wr_data), 32'(e_mon.data));
          chk("wr_ack", 32'(ack), 32'(1 << e_mon.owner));
        end
      end
      if (wr_en1) wr_count1++;
    end
  endtask

  // Requester model: advance past a beat acknowledged in the previous cycle.
  task automatic driver_step();
    for (int i = 0; i < NR; i++) begin
      if (ack_s[i] && src_ptr[i] < src_len[i]) src_ptr[i]++;
    end
    refresh_auto();
  endtask

  task automatic set_row(input int idx, input logic r, input logic l, input logic [7:0] d,
                         input logic f, input logic ew, input logic [7:0] ed, input logic eb);
    tbl[idx].req0     = r;
    tbl[idx].last0    = l;
    tbl[idx].data0    = d;
    tbl[idx].full     = f;
    tbl[idx].exp_wr   = ew;
    tbl[idx].exp_data = ed;
    tbl[idx].exp_busy = eb;
  endtask

  initial begin
    int cyc;
    n_chk = 0; n_fail = 0; wr_count = 0; wr_count1 = 0;
    rst = 1'b1; auto_en = 1'b0; fifo_full = 1'b0; ack_s = '0;
    m_req = 4'b0001; m_last = '0; m_data = 32'h0000_00A1;
    for (int i = 0; i < NR; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
    end
    refresh_auto();

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      forever begin
        @(posedge clk);
        #1;
        driver_step();
      end
    join_none

    // Reset values, with a request already pending.
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_owner", 32'(owner_id), 32'd0);
    chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Three-beat packet on requester 0, one row per cycle.
    set_row(0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b0);
    set_row(1, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, 8'hA1, 1'b1);
    set_row(2, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 8'hA2, 1'b1);
    set_row(3, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hA3, 1'b1);
    set_row(4, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) exp_q.push_back('{owner: 0, data: 8'hA1 + 8'(k)});
    for (int r = 0; r < 5; r++) begin
      m_req     = {3'b000, tbl[r].req0};
      m_last    = {3'b000, tbl[r].last0};
      m_data    = {24'h0, tbl[r].data0};
      fifo_full = tbl[r].full;
      @(negedge clk);
      chk($sformatf("t1_row%0d_wr_en", r), 32'(wr_en), 32'(tbl[r].exp_wr));
      chk($sformatf("t1_row%0d_data", r), 32'(wr_data), 32'(tbl[r].exp_data));
      chk($sformatf("t1_row%0d_busy", r), 32'(busy), 32'(tbl[r].exp_busy));
      chk($sformatf("t1_row%0d_ack", r), 32'(ack), 32'(tbl[r].exp_wr));
      tick();
    end
    chk("t1_burst_cnt", 32'(burst_cnt), 32'd1);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // All four requesting without last: grants 0,1,2,3,0, 4 beats each + 1 idle.
    do_reset();
    for (int i = 0; i < NR; i++) add_pkt(i, 8, 8'(i * 16), 1'b0, 1'b0);
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back('{owner: b % 4, data: 8'(((b % 4) * 16) + ((b / 4) * 4) + k)});
      end
    end
    cyc = 0;
    while (burst_cnt != 16'd5 && cyc < 200) begin
      tick();
      cyc++;
    end
    for (int i = 0; i < NR; i++) src_len[i] = src_ptr[i];
    refresh_auto();
    chk("t2_cycles_to_5_bursts", 32'(cyc), 32'd25);
    chk("t2_burst_cnt", 32'(burst_cnt), 32'd5);
    wait_drain("t2_drained");
    tick();
    tick();
    chk("t2_writes", 32'(wr_count), 32'd20);

    // Requester 2 stalled by full for 5 cycles after its second beat.
    do_reset();
    add_pkt(2, 4, 8'h20, 1'b0, 1'b1);
    cyc = 0;
    while (wr_count < 2 && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("t3_two_beats", 32'(wr_count), 32'd2);
    fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk($sformatf("t3_stall%0d_wr_en", s), 32'(wr_en), 32'd0);
      chk($sformatf("t3_stall%0d_ack", s), 32'(ack), 32'd0);
      chk($sformatf("t3_stall%0d_owner_busy", s), {29'b0, busy, owner_id}, {29'b0, 1'b1, 2'd2});
      tick();
    end
    fifo_full = 1'b0;
    wait_burst_cnt(1, "t3_burst_cnt");
    chk("t3_writes", 32'(wr_count), 32'd4);
    wait_drain("t3_drained");

    // Owner 1 drops after 2 beats; requester 3 is next after one idle cycle.
    do_reset();
    add_pkt(1, 2, 8'h10, 1'b0, 1'b1);
    wait_owner(1, "t4_grant1");
    add_pkt(3, 2, 8'h30, 1'b1, 1'b1);
    cyc = 0;
    while (busy && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("t4_exit_busy", 32'(busy), 32'd0);
    chk("t4_drop_not_counted", 32'(burst_cnt), 32'd0);
    tick();
    chk("t4_next_grant", {29'b0, busy, owner_id}, {29'b0, 1'b1, 2'd3});
    wait_burst_cnt(1, "t4_burst_cnt");
    wait_drain("t4_drained");

    // Single-beat packet: last and max count together count one burst.
    do_reset();
    add_pkt(0, 1, 8'h55, 1'b1, 1'b1);
    wait_burst_cnt(1, "t5_burst_cnt");
    tick();
    tick();
    chk("t5_burst_cnt_once", 32'(burst_cnt), 32'd1);
    chk("t5_max1_burst_cnt_once", 32'(burst_cnt1), 32'd1);
    chk("t5_writes", 32'(wr_count), 32'd1);
    chk("t5_max1_writes", 32'(wr_count1), 32'd1);
    add_pkt(0, 4, 8'h60, 1'b1, 1'b1);
    wait_burst_cnt(2, "t5_last_at_max");
    tick();
    tick();
    chk("t5_last_at_max_once", 32'(burst_cnt), 32'd2);
    wait_drain("t5_drained");

    // Reset in the middle of requester 3's second burst.
    do_reset();
    add_pkt(3, 2, 8'h70, 1'b1, 1'b1);
    add_pkt(3, 4, 8'h80, 1'b0, 1'b1);
    wait_burst_cnt(1, "t6_first_burst");
    wait_owner(3, "t6_second_grant");
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_wr_en", 32'(wr_en), 32'd0);
    chk("t6_rst_ack", 32'(ack), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_burst_cnt", 32'(burst_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_regrant3", {29'b0, busy, owner_id}, {29'b0, 1'b1, 2'd3});
    wait_drain("t6_drained");
    tick();
    tick();
    chk("t6_drop_not_counted", 32'(burst_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
